present_ctrl: RTL and testbench
===============================

// Module: present_ctrl
// PURPOSE
//  Sequencer for the iterative PRESENT-80 encrypt core. Accepts plaintext/key over a
//  valid/ready stream and drives the core's load/chip_enable. Checks the core's 32-cycle
//  done timing, buffers one ciphertext for a valid/ready consumer, and adds optional
//  CBC chaining. Sits between the bus-facing peripheral registers and the core.
// PARAMETERS
//  LATENCY  32  edges from core load edge to done visible (fixed by core round counter)
//  TIMEOUT  40  RUN cycles without done before abort; must be > LATENCY
// PORTS
//  clk        in   1   clock, rising edge
//  rst_n      in   1   asynchronous active-low reset
//  in_valid   in   1   plaintext/key offered
//  in_ready   out  1   comb: (state==IDLE) && (!out_valid || out_ready)
//  in_data    in   64  plaintext
//  in_key     in   80  key
//  cbc_en     in   1   sampled at accept; 1 = XOR chain register into plaintext
//  iv         in   64  initial vector
//  iv_load    in   1   chain <= iv; honoured only in IDLE, ignored otherwise
//  out_valid  out  1   ciphertext held in out_data
//  out_ready  in   1   consumer takes out_data when out_valid && out_ready
//  out_data   out  64  ciphertext buffer
//  busy       out  1   state != IDLE
//  err        out  1   sticky: premature done or timeout
//  err_clr    in   1   clears err
//  core_idat  out  64  to core idat (registered)
//  core_key   out  80  to core key (registered)
//  core_load  out  1   to core load
//  core_ce    out  1   to core chip_enable
//  core_odat  in   64  from core odat
//  core_done  in   1   from core done
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, cnt=0, out_valid=0, out_data=0, chain=0, err=0,
//   core_idat=0, core_key=0; so core_load=0, core_ce=0, busy=0, in_ready=1.
//  FSM (registered; core_load/core_ce decoded from state):
//   IDLE: ce=0, load=0. Accept (in_valid&&in_ready): core_idat<=in_data^(cbc_en?chain:0),
//    core_key<=in_key -> LOAD.
//   LOAD: one cycle, ce=1, load=1; cnt<=1 -> RUN.
//   RUN: ce=1, load=0; cnt<=cnt+1 every cycle (saturates at TIMEOUT).
//    done && cnt==LATENCY: out_data<=core_odat, out_valid<=1, chain<=core_odat -> IDLE.
//    done && cnt!=LATENCY: err<=1, no output, chain unchanged -> IDLE.
//    !done && cnt==TIMEOUT: err<=1 -> IDLE.
//  core_done is ignored outside RUN. The core has no reset and may flag done on its
//   load edge.
//  Latency: accept edge A; core load edge A+1; capture edge A+33; out_valid=1 after A+33.
//   Throughput is one block per 34 cycles with out_ready=1.
//  Output buffer: out_valid clears on out_valid&&out_ready unless a capture happens on
//   the same edge. A capture cannot coincide with a take, because accept requires the
//   buffer to be free or freeing. out_data holds its value while out_valid=1.
//  core_odat is captured on the done edge. The core zeroes odat once ce drops, so it is
//   never sampled later.
//  iv_load while accepting in IDLE: the new iv applies to this block (chain muxed first).
//  err: set wins over a simultaneous err_clr. err does not block further accepts.
//  rst_n asserted mid-RUN: immediate abort, outputs to reset values. Next block after
//   reset is correct because LOAD reinitialises the core.
// TESTING
//  1 ECB, key=0, pt=0 -> out_data=5579C1387B228445, out_valid rises 33 cycles after
//    accept, err=0.
//  2 ECB vectors: (pt FFFF..F, key 0)->A112FFC72F68417B;
//    (pt FFFF..F, key FFFF..F)->3333DCD3213210D2; back-to-back at 34-cycle spacing.
//  3 Backpressure: out_ready=0 for 50 cycles after block 1 -> out_data stable, in_ready=0,
//    no second accept. out_ready=1 -> take and accept on the same edge.
//  4 CBC: iv_load iv=0, cbc_en=1, key 0, two blocks pt=FFFF..F -> A112FFC72F68417B,
//    then E(FFFF..F ^ A112FFC72F68417B) per golden model.
//  5 Core stub: done at cnt=10 -> err=1, out_valid=0, IDLE. Stub with no done -> err=1
//    after 40 RUN cycles. err_clr -> err=0; err_clr on the set edge -> err stays 1.
//  6 rst_n low at cnt=15 -> busy=0, core_ce=0, out_valid=0; release, run test 1 -> correct.

Source files
------------

// File: rtl/present_ctrl.sv
// present_ctrl: sequencer around the iterative PRESENT-80 encrypt core.
// Accepts plaintext/key, loads the core, checks that done arrives exactly
// LATENCY cycles after the load, and buffers one ciphertext for a consumer.
// It can optionally chain the previous ciphertext into the next plaintext (CBC).
//
// state | meaning
// IDLE  | core disabled, waiting for a block (and for room in the output buffer)
// LOAD  | one cycle: core load + chip enable, operands already registered
// RUN   | core iterating; watch done against the cycle counter
module present_ctrl #(
  parameter int unsigned LATENCY = 32,
  parameter int unsigned TIMEOUT = 40
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  input  logic [79:0] in_key,
  input  logic        cbc_en,
  input  logic [63:0] iv,
  input  logic        iv_load,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        busy,
  output logic        err,
  input  logic        err_clr,
  output logic [63:0] core_idat,
  output logic [79:0] core_key,
  output logic        core_load,
  output logic        core_ce,
  input  logic [63:0] core_odat,
  input  logic        core_done
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAT = CNT_W'(LATENCY);
  localparam logic [CNT_W-1:0] CNT_TO  = CNT_W'(TIMEOUT);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [63:0]      out_data_q, out_data_d;
  logic [63:0]      chain_q, chain_d;
  logic             err_q, err_d;
  logic [63:0]      core_idat_q, core_idat_d;
  logic [79:0]      core_key_q, core_key_d;

  logic             accept;
  logic             capture;
  logic             err_set;
  logic [63:0]      chain_sel;

  assign in_ready  = (state_q == S_IDLE) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  // An iv loaded on the accept edge must already apply to that block.
  assign chain_sel = iv_load ? iv : chain_q;

  assign busy      = (state_q != S_IDLE);
  assign core_ce   = (state_q != S_IDLE);
  assign core_load = (state_q == S_LOAD);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign err       = err_q;
  assign core_idat = core_idat_q;
  assign core_key  = core_key_q;

  // Next-state logic: FSM, done/timeout checking, output buffer and error flag.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    chain_d     = chain_q;
    err_d       = err_q;
    core_idat_d = core_idat_q;
    core_key_d  = core_key_q;
    capture     = 1'b0;
    err_set     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (iv_load) chain_d = iv;
        if (accept) begin
          core_idat_d = in_data ^ (cbc_en ? chain_sel : 64'd0);
          core_key_d  = in_key;
          state_d     = S_LOAD;
        end
      end
      S_LOAD: begin
        cnt_d   = CNT_ONE;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (cnt_q != CNT_TO) cnt_d = cnt_q + CNT_ONE;
        if (core_done) begin
          // Done is only trusted on the exact cycle the round counter finishes.
          if (cnt_q == CNT_LAT) capture = 1'b1;
          else                  err_set = 1'b1;
          state_d = S_IDLE;
        end else if (cnt_q == CNT_TO) begin
          err_set = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (capture) begin
      out_valid_d = 1'b1;
      out_data_d  = core_odat;
      chain_d     = core_odat;
    end

    if (err_clr) err_d = 1'b0;
    if (err_set) err_d = 1'b1;
  end

  // State registers; reset aborts any block in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      chain_q     <= '0;
      err_q       <= 1'b0;
      core_idat_q <= '0;
      core_key_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      chain_q     <= chain_d;
      err_q       <= err_d;
      core_idat_q <= core_idat_d;
      core_key_q  <= core_key_d;
    end
  end

endmodule

// File: tb/tb_present_ctrl.sv
// Directed bench for present_ctrl with a behavioural PRESENT-80 core whose
// done timing can be moved for error-path tests.
module tb_present_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [79:0] in_key;
  logic        cbc_en;
  logic [63:0] iv;
  logic        iv_load;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        busy;
  logic        err;
  logic        err_clr;
  logic [63:0] core_idat;
  logic [79:0] core_key;
  logic        core_load;
  logic        core_ce;
  logic [63:0] core_odat;
  logic        core_done;

  int n_tests = 0;
  int n_fail  = 0;

  present_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_key(in_key),
    .cbc_en(cbc_en), .iv(iv), .iv_load(iv_load),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .err(err), .err_clr(err_clr),
    .core_idat(core_idat), .core_key(core_key), .core_load(core_load), .core_ce(core_ce),
    .core_odat(core_odat), .core_done(core_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- PRESENT-80 reference ----------------
  function automatic logic [3:0] sbox(input logic [3:0] x);
    case (x)
      4'h0: sbox = 4'hC; 4'h1: sbox = 4'h5; 4'h2: sbox = 4'h6; 4'h3: sbox = 4'hB;
      4'h4: sbox = 4'h9; 4'h5: sbox = 4'h0; 4'h6: sbox = 4'hA; 4'h7: sbox = 4'hD;
      4'h8: sbox = 4'h3; 4'h9: sbox = 4'hE; 4'hA: sbox = 4'hF; 4'hB: sbox = 4'h8;
      4'hC: sbox = 4'h4; 4'hD: sbox = 4'h7; 4'hE: sbox = 4'h1; default: sbox = 4'h2;
    endcase
  endfunction

  function automatic logic [63:0] present80(input logic [63:0] pt, input logic [79:0] key);
    logic [63:0] s, t;
    logic [79:0] k;
    logic [4:0]  rc;
    s = pt;
    k = key;
    for (int r = 1; r <= 31; r++) begin
      s = s ^ k[79:16];
      for (int i = 0; i < 16; i++) s[i*4 +: 4] = sbox(s[i*4 +: 4]);
      t = '0;
      for (int i = 0; i < 63; i++) t[(i*16) % 63] = s[i];
      t[63] = s[63];
      s = t;
      k = {k[18:0], k[79:19]};
      k[79:76] = sbox(k[79:76]);
      rc = 5'(r);
      k[19:15] = k[19:15] ^ rc;
    end
    return s ^ k[79:16];
  endfunction

  // ---------------- core model ----------------
  // done rises when r == done_r; r restarts at 0 on the load edge.
  logic [7:0]  core_r = 8'd200;
  logic [7:0]  done_r;
  logic [63:0] core_res = '0;

  always @(posedge clk) begin
    if (core_load) begin
      core_r   <= 8'd0;
      core_res <= present80(core_idat, core_key);
    end else if (core_ce && core_r < 8'd254) begin
      core_r <= core_r + 8'd1;
    end
  end
  assign core_done = (core_r == done_r);
  assign core_odat = core_ce ? core_res : 64'd0;

  // ---------------- helpers ----------------
  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Edges counted from the accept edge (exclusive) until out_valid is seen.
  task automatic wait_out(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!out_valid && n < 200);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (busy && n < 200);
  endtask

  localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] CT_00 = 64'h5579_C138_7B22_8445;
  localparam logic [63:0] CT_F0 = 64'hA112_FFC7_2F68_417B;
  localparam logic [63:0] CT_FF = 64'h3333_DCD3_2132_10D2;

  int n;
  int bad;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_key = '0; cbc_en = 1'b0;
    iv = '0; iv_load = 1'b0; out_ready = 1'b0; err_clr = 1'b0; done_r = 8'd31;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_in_ready", in_ready, 1'b1);
    chk1("rst_core_ce", core_ce, 1'b0);
    chk1("rst_core_load", core_load, 1'b0);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_err", err, 1'b0);
    chk64("rst_out_data", out_data, 64'd0);
    chk64("rst_core_idat", core_idat, 64'd0);
    chk64("rst_core_key_lo", core_key[63:0], 64'd0);
    rst_n = 1'b1;
    tick();

    // 1: ECB key 0, pt 0, consumer stalled so the buffer can be inspected
    in_data = '0; in_key = '0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk1("t1_core_load", core_load, 1'b1);
    wait_out(n);
    chki("t1_latency", n, 33);
    chk64("t1_data", out_data, CT_00);
    chk1("t1_err", err, 1'b0);
    chk1("t1_busy", busy, 1'b0);
    chk1("t1_in_ready_stalled", in_ready, 1'b0);
    out_ready = 1'b1;
    #1;
    chk1("t1_in_ready_free", in_ready, 1'b1);
    tick();
    chk1("t1_taken", out_valid, 1'b0);

    // 2: back-to-back ECB vectors at 34-cycle spacing
    in_data = ONES; in_key = '0; in_valid = 1'b1;
    tick();
    in_key = {16'hFFFF, ONES};
    wait_out(n);
    chki("t2a_latency", n, 33);
    chk64("t2a_data", out_data, CT_F0);
    tick();
    in_valid = 1'b0;
    chk1("t2b_accept_34", core_load, 1'b1);
    chk1("t2b_out_valid", out_valid, 1'b0);
    wait_out(n);
    chki("t2b_latency", n, 33);
    chk64("t2b_data", out_data, CT_FF);
    tick();

    // 3: backpressure for 50 cycles, then take and accept on the same edge
    out_ready = 1'b0;
    in_data = '0; in_key = '0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_out(n);
    chk64("t3_data", out_data, CT_00);
    in_data = ONES; in_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (out_data !== CT_00 || out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0)
        bad++;
    end
    chki("t3_stall_cycles_bad", bad, 0);
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk1("t3_take", out_valid, 1'b0);
    chk1("t3_accept", busy, 1'b1);
    chk64("t3_idat", core_idat, ONES);
    wait_out(n);
    chk64("t3_data2", out_data, CT_F0);
    tick();

    // 4: CBC with iv 0, then iv loaded on the accept edge
    iv = '0; iv_load = 1'b1;
    tick();
    iv_load = 1'b0;
    cbc_en = 1'b1; in_data = ONES; in_key = '0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk64("t4a_idat", core_idat, ONES);
    wait_out(n);
    chk64("t4a_data", out_data, CT_F0);
    tick();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk64("t4b_idat", core_idat, 64'h5EED_0038_D097_BE84);
    wait_out(n);
    chk64("t4b_data", out_data, present80(64'h5EED_0038_D097_BE84, 80'd0));
    tick();
    iv = 64'h0123_4567_89AB_CDEF; iv_load = 1'b1; in_valid = 1'b1;
    tick();
    iv_load = 1'b0; in_valid = 1'b0;
    chk64("t4c_idat", core_idat, 64'hFEDC_BA98_7654_3210);
    wait_out(n);
    chk64("t4c_data", out_data, present80(64'hFEDC_BA98_7654_3210, 80'd0));
    tick();
    cbc_en = 1'b0;

    // 5: premature done, timeout, err_clr, and set winning over clear
    done_r = 8'd9;
    in_data = '0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_idle(n);
    chki("t5a_abort_edge", n, 11);
    chk1("t5a_err", err, 1'b1);
    chk1("t5a_out_valid", out_valid, 1'b0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk1("t5a_err_clr", err, 1'b0);
    done_r = 8'd255;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_idle(n);
    chki("t5b_timeout_edge", n, 41);
    chk1("t5b_err", err, 1'b1);
    chk1("t5b_out_valid", out_valid, 1'b0);
    err_clr = 1'b1;
    tick();
    chk1("t5c_err_clr", err, 1'b0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_idle(n);
    chk1("t5c_set_wins", err, 1'b1);
    err_clr = 1'b0;

    // 6: reset mid-RUN, then a clean block
    done_r = 8'd31;
    in_data = '0; in_key = '0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (14) tick();
    rst_n = 1'b0;
    #1;
    chk1("t6_busy", busy, 1'b0);
    chk1("t6_core_ce", core_ce, 1'b0);
    chk1("t6_out_valid", out_valid, 1'b0);
    chk1("t6_err", err, 1'b0);
    #3;
    rst_n = 1'b1;
    tick();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_out(n);
    chki("t6_latency", n, 33);
    chk64("t6_data", out_data, CT_00);
    chk1("t6_err_after", err, 1'b0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
